// File: rtl/aes_round_ctrl.sv
// Sequencer for the byte-serial AES-128 core: walks the datapath through
// LOAD, 11 AddRoundKey passes and 10 rounds of Sub/Shift/Mix, fetching each round key.
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int NB_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       load_state,
  output logic       key_req,
  output logic [3:0] key_round,
  output logic [3:0] round_idx,
  output logic       sbox_en,
  output logic [3:0] byte_idx,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_BYTE  = 4'(NB_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KEY_WAIT, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] round_q, round_nxt;
  logic [3:0] byte_q, byte_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      round_q <= '0;
      byte_q  <= '0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      byte_q  <= byte_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    round_nxt  = round_q;
    byte_nxt   = byte_q;
    busy       = 1'b1;
    done       = 1'b0;
    load_state = 1'b0;
    key_req    = 1'b0;
    key_round  = '0;
    sbox_en    = 1'b0;
    shift_en   = 1'b0;
    mix_en     = 1'b0;
    ark_en     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_LOAD;
          round_nxt = '0;
        end
      end
      S_LOAD: begin
        load_state = 1'b1;
        state_nxt  = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        key_req   = 1'b1;
        key_round = round_q;
        // round 0 is only the initial key whitening
        if (key_valid) state_nxt = (round_q == '0) ? S_ARK : S_SUB;
      end
      S_SUB: begin
        sbox_en = 1'b1;
        if (byte_q == LAST_BYTE) begin
          byte_nxt  = '0;
          state_nxt = S_SHIFT;
        end else begin
          byte_nxt = byte_q + 4'd1;
        end
      end
      S_SHIFT: begin
        shift_en  = 1'b1;
        state_nxt = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
      end
      S_MIX: begin
        mix_en    = 1'b1;
        state_nxt = S_ARK;
      end
      S_ARK: begin
        ark_en    = 1'b1;
        key_round = round_q;
        if (round_q == LAST_ROUND) begin
          state_nxt = S_DONE;
        end else begin
          round_nxt = round_q + 4'd1;
          state_nxt = S_KEY_WAIT;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign round_idx = round_q;
  assign byte_idx  = byte_q;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the 8-bit-datapath AES-128 encryption core. It drives one shared byte-serial S-box, the combinational ShiftRows stage, MixColumns and AddRoundKey through the 11 AddRoundKey passes and 10 rounds of the cipher. It handshakes with the key-expansion unit for each round key. It sits between the AHB slave register block (start/done) and the state-register datapath, and holds no cipher data itself.

## Interface
Parameters:
- NR, 10, number of cipher rounds (AES-128). Only 10 is supported; it is a parameter for readability only.
- NB_BYTES, 16, state bytes processed serially per SubBytes pass.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin one block encryption; sampled only in IDLE
- key_valid  input  1  key unit presents round key `key_round` this cycle
- busy  output  1  controller not in IDLE
- done  output  1  one-cycle pulse: ciphertext valid in state register
- load_state  output  1  capture plaintext into state register
- key_req  output  1  request round key `key_round`
- key_round  output  4  round-key index requested/used (0..10)
- round_idx  output  4  current round (0..10)
- sbox_en  output  1  route state byte `byte_idx` through S-box and write back
- byte_idx  output  4  byte select during SubBytes (0..15), else 0
- shift_en  output  1  latch ShiftRows result into state register
- mix_en  output  1  latch MixColumns result into state register
- ark_en  output  1  XOR the current round key into the state register

## Operation
- States: IDLE, LOAD, KEY_WAIT, SUB, SHIFT, MIX, ARK, DONE. Encoding is free. Registered state; outputs decoded from it (Moore).
- IDLE:
  - start=1 → LOAD, with round_idx cleared to 0.
  - start=0 → stay in IDLE.
- LOAD: load_state=1 for one cycle → KEY_WAIT.
- KEY_WAIT:
  - key_req=1, key_round=round_idx.
  - key_valid=0 → stay; no other strobes.
  - key_valid=1 → exit this cycle. Round 0 → ARK; otherwise → SUB.
- SUB:
  - sbox_en=1; byte_idx counts 0..15, one byte per cycle.
  - byte_idx=15 → SHIFT, and byte_idx returns to 0.
- SHIFT: shift_en=1 for one cycle. round_idx<10 → MIX; round_idx=10 → ARK (final round skips MixColumns).
- MIX: mix_en=1 for one cycle → ARK.
- ARK: ark_en=1, key_round=round_idx for one cycle. round_idx=10 → DONE; otherwise round_idx+1 → KEY_WAIT.
- DONE: done=1 for one cycle → IDLE. start in DONE is ignored.
- start in any state other than IDLE is ignored; there is no queueing.
- key_valid outside KEY_WAIT is ignored.
- busy=1 in every state except IDLE.
- At most one of load_state/sbox_en/shift_en/mix_en/ark_en is high in any cycle.
- Counters:
  - round_idx is 4 bits and saturates at 10; it never wraps.
  - byte_idx is 4 bits and wraps 15→0 only on the SUB→SHIFT exit.
- Reset:
  - rst=1 in any state (including mid-SUB or mid-KEY_WAIT) → IDLE on the next edge.
  - Counters clear and any partial block is abandoned; the datapath state is don't-care.

## Timing
- Reset value of every output is 0: busy, done, load_state, key_req, key_round, round_idx, sbox_en, byte_idx, shift_en, mix_en, ark_en.
- Latency with key_valid held high. Take cycle 0 as the edge that samples start=1:
  - LOAD in cycle 1.
  - Round 0: KEY_WAIT + ARK, cycles 2–3.
  - Rounds 1–9: 20 cycles each (KEY_WAIT 1, SUB 16, SHIFT 1, MIX 1, ARK 1), cycles 4–183.
  - Round 10: 19 cycles, cycles 184–202.
  - done=1 in cycle 203.
  - Total 203 cycles.
- Each cycle key_valid stays low in KEY_WAIT adds exactly one cycle of latency.
- Earliest next start acceptance is cycle 204, i.e. the first IDLE cycle after done.
- Strobe totals per block:
  - load_state: 1
  - sbox_en: 160
  - shift_en: 10
  - mix_en: 9
  - ark_en: 11
  - key_req: 11 KEY_WAIT episodes

## Test plan
- Nominal, key_valid tied 1, start pulsed at cycle 0:
  - done high only in cycle 203; busy high in cycles 1–203.
  - Strobe counts are exactly 1/160/10/9/11.
  - ark_en key_round sequence is 0,1,…,10.
  - No mix_en in round 10.
- Key stall: key_valid low for 5 cycles in round 3's KEY_WAIT:
  - key_req stays high, key_round=3 throughout.
  - No data strobes during the stall.
  - done moves to cycle 208.
- SubBytes sweep: in round 1, byte_idx takes 0..15 on consecutive sbox_en cycles, and SHIFT follows byte 15 immediately.
- Start while busy: start held high from cycle 0 to 250:
  - Only one block runs, and done fires at 203.
  - A second block is accepted in cycle 204, with LOAD in cycle 205.
- Reset mid-operation: rst=1 for one cycle at round 5, byte_idx=7:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A following start gives done exactly 203 cycles later.
- Reset vs. start collision: rst=1 and start=1 in the same cycle in IDLE → stays IDLE, busy=0 the next cycle.
